ps2_transmitter: RTL and testbench

Host-to-device PS/2 transmitter: it sends one command byte (for example 0xED set-LEDs or 0xF4 enable) from the FPGA to the keyboard. It sits beside `keyboard_handler` on the shared PS2_CLK/PS2_DAT lines. It drives the lines only through open-drain enables; the top level turns them into tri-state pads. `busy` gates the receive path while a transfer is in progress.

---
 rtl/ps2_transmitter.sv | 156 +++++++++++++++
 tb/tb_ps2_transmitter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter: sends one command byte over open-drain
// PS2_CLK/PS2_DAT enables, with inhibit/request phases, ACK check and bus timeout.
module ps2_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       send,
    input  logic [7:0] command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int CMAX_A = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int CMAX   = (CMAX_A > TIMEOUT_CYCLES) ? CMAX_A : TIMEOUT_CYCLES;
    localparam int CW     = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_ACK, S_WAIT_IDLE, S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_n;
    logic [9:0]      r_frame;
    logic            r_clk_s1, r_clk_s2, r_clk_prev;
    logic            r_dat_s1, r_dat_s2;

    logic w_fall;
    logic w_to;

    assign w_fall = r_clk_prev & ~r_clk_s2;
    assign w_to   = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_n        <= '0;
            r_frame    <= '0;
            // Synchronisers reset to the idle-bus level so no false edge follows reset.
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ack_err    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            r_clk_s1   <= ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_dat_in;
            r_dat_s2   <= r_dat_s1;
            done       <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (send) begin
                        r_state    <= S_INHIBIT;
                        r_frame    <= {1'b1, ~^command, command};
                        r_cnt      <= '0;
                        busy       <= 1'b1;
                        ps2_clk_oe <= 1'b1;
                        ack_err    <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                S_INHIBIT: begin
                    if (r_cnt == CW'(INHIBIT_CYCLES - 1)) begin
                        r_state    <= S_REQ;
                        r_cnt      <= '0;
                        ps2_dat_oe <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_REQ: begin
                    if (r_cnt == CW'(REQ_CYCLES - 1)) begin
                        r_state    <= S_DATA;
                        r_cnt      <= '0;
                        r_n        <= '0;
                        ps2_clk_oe <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    // A device edge takes priority over a coincident timeout.
                    if (w_fall) begin
                        r_cnt      <= '0;
                        ps2_dat_oe <= ~r_frame[r_n];
                        r_n        <= r_n + 4'd1;
                        if (r_n == 4'd9)
                            r_state <= S_ACK;
                    end else if (w_to) begin
                        r_state    <= S_DONE;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        timeout    <= 1'b1;
                        done       <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    if (w_fall) begin
                        ack_err <= r_dat_s2;
                        r_cnt   <= '0;
                        r_state <= S_WAIT_IDLE;
                    end else if (w_to) begin
                        r_state    <= S_DONE;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        timeout    <= 1'b1;
                        done       <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (r_clk_s2 && r_dat_s2) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                    end else if (w_to) begin
                        r_state    <= S_DONE;
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        timeout    <= 1'b1;
                        done       <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: a behavioural PS/2 device clocks frames out of the
// DUT; expected frames and completion flags are queued at send and checked on output.
module tb_ps2_transmitter;

    localparam int INH = 5000;
    localparam int REQ = 50;
    localparam int TO  = 1000;
    localparam int H   = 50;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       send = 1'b0;
    logic [7:0] command = 8'h00;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout;

    assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

    ps2_transmitter #(
        .INHIBIT_CYCLES (INH),
        .REQ_CYCLES     (REQ),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .send       (send),
        .command    (command),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .timeout    (timeout)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    int done_cnt = 0;
    int clk_hi = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (ps2_clk_oe) clk_hi <= clk_hi + 1;
    end

    int errs = 0;
    int checks = 0;
    logic [10:0] exp_frame_q[$];
    logic [1:0]  exp_flag_q[$];   // {ack_err, timeout}

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_send(input logic [7:0] c, input logic [1:0] flags);
        @(negedge clk);
        command = c;
        send = 1'b1;
        exp_frame_q.push_back({1'b1, ~^c, c, 1'b0});
        exp_flag_q.push_back(flags);
        @(negedge clk);
        send = 1'b0;
        command = ~c;
        chk("accept_busy", {31'd0, busy}, 32'd1);
        chk("accept_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);
    endtask

    // mode 0: ACK, 1: no ACK, 2: reset after edge 4, 3: extra send after edge 4
    task automatic device(input int mode);
        int t;
        logic [10:0] rx;
        logic [10:0] ef;
        logic [1:0]  fl;
        t = 0;
        rx = '0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && t < INH + REQ + 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= INH + REQ + 100) begin
            chk("req_wait", 32'd0, 32'd1);
            return;
        end
        repeat (20) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            rx[i] = ps2_dat_in;
            if (i == 10) begin
                if (mode != 1) dev_dat = 1'b0;
                repeat (5) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            if (i == 10) begin
                dev_dat = 1'b1;
                break;
            end
            repeat (H) @(negedge clk);
            if (i == 3 && mode == 2) begin
                chk("pre_reset_dat_oe", {31'd0, ps2_dat_oe}, 32'd1);
                resetn = 1'b0;
                #1;
                chk("reset_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
                chk("reset_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
                chk("reset_busy", {31'd0, busy}, 32'd0);
                ef = exp_frame_q.pop_front();
                fl = exp_flag_q.pop_front();
                repeat (5) @(negedge clk);
                resetn = 1'b1;
                return;
            end
            if (i == 3 && mode == 3) begin
                command = 8'h00;
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
            end
        end
        ef = exp_frame_q.pop_front();
        chk("frame", {21'd0, rx}, {21'd0, ef});
    endtask

    task automatic wait_done();
        int t;
        logic [1:0] fl;
        t = 0;
        while (!done && t < 4 * TO) begin
            @(negedge clk);
            t++;
        end
        if (!done) begin
            chk("done_wait", 32'd0, 32'd1);
            return;
        end
        fl = exp_flag_q.pop_front();
        chk("ack_err", {31'd0, ack_err}, {31'd0, fl[1]});
        chk("timeout", {31'd0, timeout}, {31'd0, fl[0]});
        @(negedge clk);
        chk("post_done", {29'd0, busy, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        chk("done_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int base_done, base_hi, t0, t;
        logic [10:0] ef;

        repeat (3) @(negedge clk);
        chk("rst_outs", {26'd0, ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout}, 32'd0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // Reset mid-DATA: lines released at once, no done.
        base_done = done_cnt;
        do_send(8'h00, 2'b00);
        device(2);
        repeat (100) @(negedge clk);
        chk("reset_no_done", done_cnt - base_done, 32'd0);
        chk("reset_idle", {30'd0, busy, ps2_clk_oe}, 32'd0);

        // 0xED with ACK, full inhibit after the aborted transfer.
        base_done = done_cnt;
        base_hi = clk_hi;
        do_send(8'hED, 2'b00);
        device(0);
        wait_done();
        chk("clk_oe_cycles", clk_hi - base_hi, INH + REQ);
        chk("ed_one_done", done_cnt - base_done, 32'd1);

        // 0xF4 with ACK (parity 0).
        do_send(8'hF4, 2'b00);
        device(0);
        wait_done();

        // Device never clocks.
        do_send(8'hA5, 2'b01);
        ef = exp_frame_q.pop_front();
        t = 0;
        while (ps2_clk_oe && t < INH + REQ + 100) begin
            @(negedge clk);
            t++;
        end
        t0 = cyc;
        wait_done();
        chk("timeout_latency", cyc - t0 - 1, TO);

        // No ACK from device; flags persist after done.
        do_send(8'h3C, 2'b10);
        device(1);
        wait_done();
        repeat (50) @(negedge clk);
        chk("ack_err_hold", {30'd0, ack_err, timeout}, 32'd2);

        // Send during DATA is ignored.
        base_done = done_cnt;
        do_send(8'h96, 2'b00);
        device(3);
        wait_done();
        repeat (200) @(negedge clk);
        chk("ignored_one_done", done_cnt - base_done, 32'd1);
        chk("ignored_idle", {31'd0, busy}, 32'd0);
        chk("flags_cleared", {30'd0, ack_err, timeout}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
